// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes and the parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_ERROR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

    // Falls counted on the wire: 8 data, parity, stop, then the device ACK
    localparam logic [3:0] PS2_STOP_FALL_IDX = 4'd9;
    localparam int         PS2_MAX_RETRIES   = 2;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data pins and flags falling edges of the synced clock.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic c_in,
    input  logic d_in,
    output logic c_sync,
    output logic d_sync,
    output logic c_fall
);

    logic [SYNC_STAGES-1:0] c_sr;
    logic [SYNC_STAGES-1:0] d_sr;
    logic                   c_prev;

    // Idle bus is high, so reset to 1 to avoid a phantom fall after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            c_sr   <= '1;
            d_sr   <= '1;
            c_prev <= 1'b1;
        end else begin
            c_sr   <= {c_sr[SYNC_STAGES-2:0], c_in};
            d_sr   <= {d_sr[SYNC_STAGES-2:0], d_in};
            c_prev <= c_sr[SYNC_STAGES-1];
        end
    end

    assign c_sync = c_sr[SYNC_STAGES-1];
    assign d_sync = d_sr[SYNC_STAGES-1];
    assign c_fall = c_prev & ~c_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data through output enables.
// Optional build macro PS2_TX_RETRY_EN: resend the latched byte up to two extra times before tx_err.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_c_in,
    input  logic       ps2_d_in,
    output logic       ps2_c_oe,
    output logic       ps2_d_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_t state, state_nxt;

    logic          c_sync, d_sync, c_fall;
    logic [7:0]    data_q;
    logic          par_q;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic          d_drive;
    logic          accept;
    logic          timeout;
    logic          inhibit_end;
    logic          retry;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .c_in   (ps2_c_in),
        .d_in   (ps2_d_in),
        .c_sync (c_sync),
        .d_sync (d_sync),
        .c_fall (c_fall)
    );

    assign accept      = tx_valid && (state == ST_IDLE);
    assign timeout     = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign inhibit_end = (icnt == IW'(INHIBIT_CYCLES));

`ifdef PS2_TX_RETRY_EN
    logic [1:0] attempt;

    assign retry = (attempt < 2'(PS2_MAX_RETRIES));

    always_ff @(posedge clk) begin
        if (rst)
            attempt <= '0;
        else if (accept)
            attempt <= '0;
        else if (state == ST_ERROR && retry)
            attempt <= attempt + 2'd1;
    end
`else
    assign retry = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (accept) state_nxt = ST_INHIBIT;
            ST_INHIBIT:   if (inhibit_end) state_nxt = ST_REQ;
            ST_REQ: begin
                if (c_fall) begin
                    if (bit_cnt == PS2_STOP_FALL_IDX) state_nxt = ST_ACK;
                end else if (timeout) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_ACK: begin
                if (c_fall)       state_nxt = d_sync ? ST_ERROR : ST_WAIT_IDLE;
                else if (timeout) state_nxt = ST_ERROR;
            end
            ST_WAIT_IDLE: begin
                if (c_sync && d_sync) state_nxt = ST_IDLE;
                else if (timeout)     state_nxt = ST_ERROR;
            end
            ST_ERROR:     state_nxt = retry ? ST_INHIBIT : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        ps2_c_oe = (state == ST_INHIBIT);
        ps2_d_oe = 1'b0;
        tx_done  = 1'b0;
        tx_err   = 1'b0;
        case (state)
            ST_INHIBIT:   ps2_d_oe = inhibit_end;
            ST_REQ:       ps2_d_oe = d_drive;
            ST_WAIT_IDLE: tx_done  = c_sync && d_sync;
            ST_ERROR:     tx_err   = ~retry;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            icnt    <= '0;
            tcnt    <= '0;
            d_drive <= 1'b1;
        end else begin
            if (accept) begin
                data_q <= tx_data;
                par_q  <= odd_parity(tx_data);
            end

            if (state == ST_INHIBIT)
                icnt <= icnt + IW'(1);
            else
                icnt <= '0;

            if (state == ST_INHIBIT)
                bit_cnt <= '0;
            else if (c_fall && (state == ST_REQ || state == ST_ACK))
                bit_cnt <= bit_cnt + 4'd1;

            // Held at zero through INHIBIT so the count starts fresh on REQ entry
            if (state == ST_INHIBIT || c_fall)
                tcnt <= '0;
            else if (state == ST_REQ || state == ST_ACK || state == ST_WAIT_IDLE)
                tcnt <= tcnt + TW'(1);

            if (state == ST_INHIBIT) begin
                d_drive <= 1'b1;
            end else if (state == ST_REQ && c_fall) begin
                case (bit_cnt)
                    4'd0, 4'd1, 4'd2, 4'd3,
                    4'd4, 4'd5, 4'd6, 4'd7: d_drive <= ~data_q[bit_cnt[2:0]];
                    4'd8:                   d_drive <= ~par_q;
                    default:                d_drive <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a small open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int N    = 100;
    localparam int T    = 1000;
    localparam int HALF = 10;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps2_c_in, ps2_d_in, ps2_c_oe, ps2_d_oe;
    logic       dev_c_low, dev_d_low;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_c_in = ~(ps2_c_oe | dev_c_low);
    assign ps2_d_in = ~(ps2_d_oe | dev_d_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(N), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .busy     (busy),
        .ps2_c_in (ps2_c_in),
        .ps2_d_in (ps2_d_in),
        .ps2_c_oe (ps2_c_oe),
        .ps2_d_oe (ps2_d_oe)
    );

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a byte, wait for accept, then verify the inhibit/start-bit/request sequence
    task automatic send_byte(input logic [7:0] b);
        int n;
        tx_data  = b;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 20000, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (ps2_c_oe && !ps2_d_oe && n < N + 50) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, N);
        chk("start_bit", {ps2_c_oe, ps2_d_oe}, 2'b11);
        @(negedge clk);
        chk("req_lines", {ps2_c_oe, ps2_d_oe}, 2'b01);
    endtask

    // Device clocks 11 falls; samples in the high phase; optional ACK and reset at a given fall
    task automatic dev_frame(input logic ack, input int abort_fall, output logic [9:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (!(!ps2_c_oe && ps2_d_oe) && n < N + T + 100) begin
            @(negedge clk);
            n++;
        end
        chk("dev_req_wait", n < N + T + 100, 1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_d_low = ack;
            dev_c_low = 1'b1;
            if (i + 1 == abort_fall) begin
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                dev_c_low = 1'b0;
                dev_d_low = 1'b0;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            if (i < 10) bits[i] = ps2_d_in;
            repeat (HALF / 2) @(negedge clk);
            if (i == 10) dev_d_low = 1'b0;
        end
    endtask

    task automatic frame_ok(input string tag, input logic [7:0] b, input logic exp_par);
        logic [9:0] bits;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b);
        dev_frame(1'b1, 0, bits);
        chk({tag, "_data"}, bits[7:0], b);
        chk({tag, "_par"}, bits[8], exp_par);
        chk({tag, "_stop"}, bits[9], 1'b1);
        repeat (10) @(negedge clk);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err_cnt - e0, 0);
        chk({tag, "_ready"}, tx_ready, 1'b1);
    endtask

    initial begin
        logic [9:0] bits;
        int         d0, e0, n, attempts, req_n;
        logic       in_req, prev_c;

        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = '0;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulses", {tx_done, tx_err}, 2'b00);
        chk("rst_oe", {ps2_c_oe, ps2_d_oe}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // ED = 1110_1101: LSB-first 1,0,1,1,0,1,1,1; six ones -> odd parity 1
        frame_ok("set_leds", PS2_CMD_SET_LEDS, 1'b1);
        frame_ok("zero", 8'h00, 1'b1);
        frame_ok("one", 8'h01, 1'b0);

        // Device never clocks: timeout T cycles after each request
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h3C);
        attempts = 1;
        req_n    = 0;
        in_req   = 1'b1;
        prev_c   = 1'b0;
        n        = 0;
        while (!tx_err && n < 3 * (N + T + 50)) begin
            @(negedge clk);
            n++;
            req_n++;
            if (!ps2_c_oe && ps2_d_oe && !in_req) req_n = 0;
            in_req = !ps2_c_oe && ps2_d_oe;
            if (ps2_c_oe && !prev_c) attempts++;
            prev_c = ps2_c_oe;
        end
        chk("to_seen", tx_err, 1'b1);
        chk("to_cycles", req_n, T);
        chk("to_attempts", attempts, ATTEMPTS);
        chk("to_oe", {ps2_c_oe, ps2_d_oe}, 2'b00);
        @(negedge clk);
        chk("to_ready", tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("to_err_cnt", err_cnt - e0, 1);
        chk("to_done_cnt", done_cnt - d0, 0);

        // NACK: data left high at fall #11
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        for (int k = 0; k < ATTEMPTS; k++) begin
            dev_frame(1'b0, 0, bits);
            chk("nack_data", bits[7:0], 8'hA5);
        end
        repeat (10) @(negedge clk);
        chk("nack_err", err_cnt - e0, 1);
        chk("nack_done", done_cnt - d0, 0);
        chk("nack_ready", tx_ready, 1'b1);

        // Reset while the device holds the clock low for fall #5
        e0 = err_cnt;
        send_byte(8'h96);
        dev_frame(1'b1, 5, bits);
        chk("abort_oe", {ps2_c_oe, ps2_d_oe}, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", tx_ready, 1'b1);
        repeat (10) @(negedge clk);
        chk("abort_no_err", err_cnt - e0, 0);
        frame_ok("reset_cmd", PS2_CMD_RESET, 1'b1);

        // Valid pulsed while busy is dropped; the latched byte is unaffected
        d0 = done_cnt;
        send_byte(8'h55);
        tx_data  = PS2_CMD_ENABLE;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b1, 0, bits);
        chk("busy_pulse_data", bits[7:0], 8'h55);
        chk("busy_pulse_par", bits[8], 1'b1);
        repeat (20) @(negedge clk);
        chk("busy_pulse_done", done_cnt - d0, 1);
        chk("busy_pulse_idle", busy, 1'b0);
        // F4 = 1111_0100: five ones -> parity 0
        frame_ok("enable", PS2_CMD_ENABLE, 1'b0);

        chk("done_err_overlap", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
